screen_blitter: RTL and testbench
=================================

// Module: screen_blitter
// PURPOSE
//  Parametrised full-frame raster blitter: scans a WIDTH x HEIGHT frame, reads one
//  of NSCREENS screen ROMs (title/game/win/lose/...) and drives the vga_adapter
//  pixel port.
//  Frames start on request or automatically on a screen change. Pixel coordinates
//  stay aligned with ROM read latency, and busy/done report frame progress.
//  Sits between the game-state FSM (provides screen_sel) and the vga_adapter.
// PARAMETERS
//  WIDTH        160  frame width in pixels
//  HEIGHT       120  frame height in pixels
//  XW           8    x coordinate width, 2**XW >= WIDTH
//  YW           7    y coordinate width, 2**YW >= HEIGHT
//  ADDRW        15   ROM address width, 2**ADDRW >= WIDTH*HEIGHT
//  CW           3    colour bits per pixel
//  NSCREENS     4    number of screen ROMs
//  SELW         2    screen select width, 2**SELW >= NSCREENS
//  ROM_LATENCY  1    ROM read latency in clocks (>=1)
//  AUTO_REDRAW  1    1: a screen_sel change triggers a redraw; 0: only start does
// PORTS
//  Clock       in   1               system clock
//  Reset       in   1               synchronous, active-low reset
//  start       in   1               redraw request, level sampled each clock
//  screen_sel  in   SELW            screen to draw
//  rom_addr    out  ADDRW           shared ROM address, y*WIDTH+x
//  rom_data    in   NSCREENS*CW     ROM outputs; screen i at [i*CW +: CW]
//  oX          out  XW              pixel x to VGA
//  oY          out  YW              pixel y to VGA
//  oColour     out  CW              pixel colour to VGA
//  plot        out  1               write strobe to VGA
//  busy        out  1               frame in progress (FILL or DRAIN)
//  done        out  1               one-cycle pulse, frame complete
// BEHAVIOUR
//  Reset (Reset==0 at posedge)
//   - state=IDLE; all outputs 0; pipeline valids 0; pending=0.
//   - last_sel=screen_sel, so no spurious auto-redraw after reset.
//   - Reset mid-frame aborts immediately; no further plot.
//  States: IDLE -> FILL -> DRAIN -> IDLE.
//  IDLE
//   - go = start | pending | (AUTO_REDRAW & screen_sel!=last_sel).
//   - On go: latch act_sel=screen_sel and last_sel=screen_sel; clear pending;
//     x=y=0; enter FILL.
//  FILL (one address per clock)
//   - rom_addr=y*WIDTH+x, registered and computed from the counters (ADDRW bits,
//     no truncation).
//   - x counts 0..WIDTH-1, then wraps to 0 and y increments.
//   - After address (WIDTH-1,HEIGHT-1), enter DRAIN.
//   - FILL lasts exactly WIDTH*HEIGHT cycles.
//  DRAIN
//   - Lasts ROM_LATENCY+1 cycles to flush the pipeline, then IDLE.
//  Pipeline
//   - x, y and valid are delayed ROM_LATENCY+1 clocks behind rom_addr.
//   - oColour = registered rom_data[act_sel*CW +: CW].
//   - plot = delayed valid. oX/oY/oColour update only when plot=1; otherwise they
//     hold their last value.
//  Timing
//   - start sampled at edge t: first rom_addr valid after t+1.
//   - plot for (0,0) at edge t+2+ROM_LATENCY.
//   - Last plot in the final DRAIN cycle; done=1 for the next cycle, state IDLE.
//  busy = (state==FILL)|(state==DRAIN); it falls in the same cycle done rises.
//  While busy
//   - act_sel is frozen.
//   - start=1 sets pending.
//   - With AUTO_REDRAW, screen_sel!=last_sel sets pending; last_sel updates on
//     relatch.
//   - Pending requests coalesce: at most one extra frame, using screen_sel
//     sampled at relatch.
//   - done and go in the same IDLE cycle: the new frame starts (no idle gap
//     beyond that cycle).
//  act_sel >= NSCREENS: colour forced to 0 (black); the frame still completes.
// STRUCTURE
//  Shared package vga_pkg
//   - Resolution constants (SCR_W=160, SCR_H=120), colour width, screen IDs
//     (SCR_TITLE=0, SCR_GAME=1, SCR_WIN=2, SCR_LOSE=3).
//   - State encoding localparams.
//  Sub-module blit_delay_line #(W,DEPTH)
//   - Resettable shift register carrying {valid,x,y} for ROM_LATENCY+1 stages.
//  Top holds: FSM, x/y counters, address multiply-add, pending/last_sel logic,
//  colour mux.
// TESTING
//  1. W=4,H=3,L=1, start pulse at edge 0 -> 12 plots at edges 3..14, raster order;
//     oX/oY (0,0)..(3,2); done=1 for the cycle after edge 14; busy spans edges 1..14.
//  2. Default 160x120, sel=2, ROM returns address LSBs -> exactly 19200 plots.
//     rom_addr of pixel (159,119)=19199; colour matches ROM2; done pulses once.
//  3. AUTO_REDRAW=1, sel 0->1 at pixel 50 -> current frame finishes with ROM0.
//     A second frame of ROM1 starts right after done, with no start pulse.
//  4. start held high for 3 cycles mid-frame -> exactly one extra frame.
//     AUTO_REDRAW=0 with a sel change and no start -> no redraw.
//  5. Reset low mid-frame -> plot=0 the next cycle; outputs 0; state IDLE.
//     After reset release, no plot until start.
//  6. L=3, W=4,H=3 -> first plot at edge 5; DRAIN lasts 4 cycles.
//     sel=5 with NSCREENS=4 -> all colours 0, done still pulses.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA definitions: resolution, colour depth, screen IDs and blitter state encoding.
package vga_pkg;

  localparam int SCR_W    = 160;
  localparam int SCR_H    = 120;
  localparam int COLOUR_W = 3;

  localparam logic [1:0] SCR_TITLE = 2'd0;
  localparam logic [1:0] SCR_GAME  = 2'd1;
  localparam logic [1:0] SCR_WIN   = 2'd2;
  localparam logic [1:0] SCR_LOSE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } blit_state_t;

endpackage

// File: rtl/blit_delay_line.sv
// Resettable shift register that keeps {valid,x,y} aligned with ROM read latency.
module blit_delay_line #(
  parameter int W     = 1,
  parameter int DEPTH = 2
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stage [DEPTH];

  // NOTE: every stage is cleared, not just valid, so a reset leaves no stale
  // coordinates behind; this keeps the line as flops rather than a RAM.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/screen_blitter.sv
// Full-frame raster blitter: scans the frame, reads the selected screen ROM and plots it.
module screen_blitter
  import vga_pkg::*;
#(
  parameter int WIDTH       = SCR_W,
  parameter int HEIGHT      = SCR_H,
  parameter int XW          = 8,
  parameter int YW          = 7,
  parameter int ADDRW       = 15,
  parameter int CW          = COLOUR_W,
  parameter int NSCREENS    = 4,
  parameter int SELW        = 2,
  parameter int ROM_LATENCY = 1,
  parameter int AUTO_REDRAW = 1
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   start,
  input  logic [SELW-1:0]        screen_sel,
  output logic [ADDRW-1:0]       rom_addr,
  input  logic [NSCREENS*CW-1:0] rom_data,
  output logic [XW-1:0]          oX,
  output logic [YW-1:0]          oY,
  output logic [CW-1:0]          oColour,
  output logic                   plot,
  output logic                   busy,
  output logic                   done
);

  localparam int DW = $clog2(ROM_LATENCY + 1) + 1;
  localparam int PW = 1 + XW + YW;

  blit_state_t     state, state_next;
  logic [XW-1:0]   x_cnt;
  logic [YW-1:0]   y_cnt;
  logic [DW-1:0]   drain_cnt;
  logic [SELW-1:0] act_sel, last_sel;
  logic            pending;
  logic            sel_changed, go, last_x, last_y, drain_end;
  logic [PW-1:0]   pipe_in, pipe_out;
  logic            d_valid;
  logic [XW-1:0]   d_x;
  logic [YW-1:0]   d_y;
  logic [CW-1:0]   colour_mux;

  assign sel_changed = (AUTO_REDRAW != 0) && (screen_sel != last_sel);
  assign go          = start || pending || sel_changed;
  assign last_x      = (x_cnt == XW'(WIDTH - 1));
  assign last_y      = (y_cnt == YW'(HEIGHT - 1));
  assign drain_end   = (drain_cnt == DW'(ROM_LATENCY));
  assign busy        = (state == ST_FILL) || (state == ST_DRAIN);

  // NOTE: assign every always_comb output a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (go) state_next = ST_FILL;
      ST_FILL:  if (last_x && last_y) state_next = ST_DRAIN;
      ST_DRAIN: if (drain_end) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // NOTE: reset here is synchronous (sampled on Clock), and all state uses
  // non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state     <= ST_IDLE;
      x_cnt     <= '0;
      y_cnt     <= '0;
      drain_cnt <= '0;
      act_sel   <= '0;
      last_sel  <= screen_sel;
      pending   <= 1'b0;
      rom_addr  <= '0;
      done      <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state == ST_DRAIN) && drain_end;
      case (state)
        ST_IDLE: begin
          if (go) begin
            act_sel  <= screen_sel;
            last_sel <= screen_sel;
            pending  <= 1'b0;
            x_cnt    <= '0;
            y_cnt    <= '0;
          end
        end
        ST_FILL: begin
          rom_addr  <= ADDRW'(y_cnt) * ADDRW'(WIDTH) + ADDRW'(x_cnt);
          drain_cnt <= '0;
          if (last_x) begin
            x_cnt <= '0;
            if (!last_y) y_cnt <= y_cnt + 1'b1;
          end else begin
            x_cnt <= x_cnt + 1'b1;
          end
          if (start || sel_changed) pending <= 1'b1;
        end
        ST_DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (start || sel_changed) pending <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Coordinates ride alongside the ROM access so they meet the returned colour.
  assign pipe_in = {state == ST_FILL, x_cnt, y_cnt};

  blit_delay_line #(
    .W     (PW),
    .DEPTH (ROM_LATENCY + 1)
  ) u_delay (
    .Clock (Clock),
    .Reset (Reset),
    .din   (pipe_in),
    .dout  (pipe_out)
  );

  assign {d_valid, d_x, d_y} = pipe_out;

  // Out-of-range screen selects fall through to black.
  always_comb begin
    colour_mux = '0;
    for (int i = 0; i < NSCREENS; i++)
      if (32'(act_sel) == i) colour_mux = rom_data[i*CW +: CW];
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      plot    <= 1'b0;
      oX      <= '0;
      oY      <= '0;
      oColour <= '0;
    end else begin
      plot <= d_valid;
      if (d_valid) begin
        oX      <= d_x;
        oY      <= d_y;
        oColour <= colour_mux;
      end
    end
  end

endmodule

// File: tb/tb_screen_blitter.sv
// Directed bench: three blitter instances (4x3 L=1 auto, 4x3 L=3 manual, full 160x120).
module tb_screen_blitter;
  import vga_pkg::*;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  // Instance A: 4x3, latency 1, auto redraw, 3-bit select to reach sel=5.
  logic        Reset_a, start_a, plot_a, busy_a, done_a;
  logic [2:0]  sel_a, col_a;
  logic [14:0] addr_a;
  logic [11:0] rom_a;
  logic [7:0]  oX_a;
  logic [6:0]  oY_a;

  // Instance B: 4x3, latency 3, no auto redraw.
  logic        Reset_b, start_b, plot_b, busy_b, done_b;
  logic [1:0]  sel_b;
  logic [2:0]  col_b;
  logic [14:0] addr_b;
  logic [11:0] rom_b, rom_b_p1, rom_b_p2;
  logic [7:0]  oX_b;
  logic [6:0]  oY_b;

  // Instance C: default 160x120.
  logic        Reset_c, start_c, plot_c, busy_c, done_c;
  logic [1:0]  sel_c;
  logic [2:0]  col_c;
  logic [14:0] addr_c;
  logic [11:0] rom_c;
  logic [7:0]  oX_c;
  logic [6:0]  oY_c;

  screen_blitter #(.WIDTH(4), .HEIGHT(3), .SELW(3), .ROM_LATENCY(1), .AUTO_REDRAW(1)) dut_a (
    .Clock(Clock), .Reset(Reset_a), .start(start_a), .screen_sel(sel_a), .rom_addr(addr_a),
    .rom_data(rom_a), .oX(oX_a), .oY(oY_a), .oColour(col_a), .plot(plot_a), .busy(busy_a),
    .done(done_a));

  screen_blitter #(.WIDTH(4), .HEIGHT(3), .ROM_LATENCY(3), .AUTO_REDRAW(0)) dut_b (
    .Clock(Clock), .Reset(Reset_b), .start(start_b), .screen_sel(sel_b), .rom_addr(addr_b),
    .rom_data(rom_b), .oX(oX_b), .oY(oY_b), .oColour(col_b), .plot(plot_b), .busy(busy_b),
    .done(done_b));

  screen_blitter dut_c (
    .Clock(Clock), .Reset(Reset_c), .start(start_c), .screen_sel(sel_c), .rom_addr(addr_c),
    .rom_data(rom_c), .oX(oX_c), .oY(oY_c), .oColour(col_c), .plot(plot_c), .busy(busy_c),
    .done(done_c));

  // Screen i holds colour (address + i) mod 8 at every address.
  function automatic logic [11:0] rom_word(input int addr);
    logic [11:0] w;
    for (int i = 0; i < 4; i++) w[i*3 +: 3] = 3'(addr + i);
    return w;
  endfunction

  function automatic logic [2:0] exp_col(input int k, input int s);
    return (s < 4) ? 3'(k + s) : 3'd0;
  endfunction

  always @(posedge Clock) begin
    rom_a    <= rom_word(int'(addr_a));
    rom_b_p1 <= rom_word(int'(addr_b));
    rom_b_p2 <= rom_b_p1;
    rom_b    <= rom_b_p2;
    rom_c    <= rom_word(int'(addr_c));
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  // Called just after the go edge of a frame on A; checks edges 1..14 of that frame.
  task automatic watch_a(input int s, input int chg_e, input logic [2:0] new_sel,
                         input int st_from, input int st_to);
    int k;
    for (int e = 1; e <= 14; e++) begin
      cycle();
      if (e == chg_e) sel_a = new_sel;
      start_a = (e >= st_from) && (e < st_to);
      check("a_busy", busy_a, e < 14);
      check("a_done", done_a, e == 14);
      if (e <= 12) check("a_addr", addr_a, e - 1);
      if (e >= 3) begin
        k = e - 3;
        check("a_plot", plot_a, 1);
        check("a_x", oX_a, k % 4);
        check("a_y", oY_a, k / 4);
        check("a_col", col_a, exp_col(k, s));
      end else begin
        check("a_plot_early", plot_a, 0);
      end
    end
    start_a = 1'b0;
  endtask

  initial begin
    int k, ex, ey, nplot, ndone, bad, first_e, done_e;
    Reset_a = 0; Reset_b = 0; Reset_c = 0;
    start_a = 0; start_b = 0; start_c = 0;
    sel_a = 3'd0; sel_b = 2'd3; sel_c = SCR_WIN;
    repeat (2) cycle();
    check("rst_plot", plot_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_addr", addr_a, 0);
    check("rst_xy", {oX_a, oY_a}, 0);
    check("rst_col", col_a, 0);
    Reset_a = 1; Reset_b = 1; Reset_c = 1;
    repeat (2) cycle();
    check("post_rst_idle", busy_a, 0);

    // Single frame on A from a one-cycle start.
    start_a = 1;
    cycle();
    start_a = 0;
    check("a_go_busy", busy_a, 1);
    watch_a(0, -1, 3'd0, -1, -1);
    cycle();
    check("a_hold_plot", plot_a, 0);
    check("a_hold_x", oX_a, 3);
    check("a_hold_y", oY_a, 2);
    check("a_hold_col", col_a, exp_col(11, 0));
    check("a_hold_done", done_a, 0);

    // Screen change mid-frame: frame finishes with ROM0, ROM1 frame follows unprompted.
    start_a = 1;
    cycle();
    start_a = 0;
    watch_a(0, 6, 3'd1, -1, -1);
    check("a_done_busy_low", busy_a, 0);
    cycle();
    check("a_auto_busy", busy_a, 1);
    watch_a(1, -1, 3'd0, -1, -1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("a_auto_quiet", busy_a, 0);
    end

    // Start held three cycles mid-frame: exactly one extra frame.
    start_a = 1;
    cycle();
    start_a = 0;
    watch_a(1, -1, 3'd0, 5, 8);
    cycle();
    check("a_extra_busy", busy_a, 1);
    watch_a(1, -1, 3'd0, -1, -1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("a_extra_quiet", busy_a, 0);
    end

    // Out-of-range screen: black frame that still completes.
    sel_a = 3'd5;
    cycle();
    check("a_sel5_busy", busy_a, 1);
    watch_a(5, -1, 3'd0, -1, -1);

    // Reset mid-frame aborts; no plot afterwards without a request.
    cycle();
    sel_a = 3'd2;
    cycle();
    check("a_rstmid_busy", busy_a, 1);
    repeat (6) cycle();
    check("a_rstmid_plot_before", plot_a, 1);
    Reset_a = 0;
    cycle();
    check("a_abort_plot", plot_a, 0);
    check("a_abort_busy", busy_a, 0);
    check("a_abort_done", done_a, 0);
    check("a_abort_xy", {oX_a, oY_a}, 0);
    check("a_abort_col", col_a, 0);
    check("a_abort_addr", addr_a, 0);
    Reset_a = 1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("a_after_rst_plot", plot_a, 0);
      check("a_after_rst_busy", busy_a, 0);
    end

    // Latency 3 on B: first plot at edge 5, drain of 4 cycles, done after edge 16.
    start_b = 1;
    cycle();
    start_b = 0;
    for (int e = 1; e <= 18; e++) begin
      cycle();
      check("b_busy", busy_b, e < 16);
      check("b_done", done_b, e == 16);
      if (e >= 5 && e <= 16) begin
        k = e - 5;
        check("b_plot", plot_b, 1);
        check("b_x", oX_b, k % 4);
        check("b_y", oY_b, k / 4);
        check("b_col", col_b, exp_col(k, 3));
      end else begin
        check("b_plot_off", plot_b, 0);
      end
    end
    // Without auto redraw a screen change alone starts nothing.
    sel_b = 2'd1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      check("b_no_auto", {busy_b, plot_b}, 0);
    end

    // Full 160x120 frame on C using screen WIN.
    start_c = 1;
    cycle();
    start_c = 0;
    ex = 0; ey = 0; nplot = 0; ndone = 0; bad = 0; first_e = -1; done_e = -1;
    for (int e = 1; e <= 19210; e++) begin
      cycle();
      if (e == 19200) check("c_last_addr", addr_c, 19199);
      if (plot_c) begin
        if (first_e < 0) first_e = e;
        if (oX_c != 8'(ex) || oY_c != 7'(ey) || col_c != 3'(ey * 160 + ex + 2)) bad++;
        nplot++;
        if (ex == 159) begin ex = 0; ey++; end else ex++;
      end
      if (done_c) begin
        ndone++;
        done_e = e;
      end
    end
    check("c_plots", nplot, 19200);
    check("c_pixel_bad", bad, 0);
    check("c_first_plot_edge", first_e, 3);
    check("c_done_count", ndone, 1);
    check("c_done_edge", done_e, 19202);
    check("c_idle", busy_c, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
